// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: FSM state encoding and the
// default configuration layout {high, low, prescale}.
`timescale 1ns/1ps
package pwm_pkg;

  localparam int unsigned CNT_WIDTH_DEF      = 32;
  localparam int unsigned PRESCALE_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  typedef struct packed {
    logic [CNT_WIDTH_DEF-1:0]      high;
    logic [CNT_WIDTH_DEF-1:0]      low;
    logic [PRESCALE_WIDTH_DEF-1:0] prescale;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Tick divider: counts 0..P and pulses tick on reaching P, so a tick arrives
// every P+1 clocks. clear restarts the count so a phase always begins aligned.
`timescale 1ns/1ps
module pwm_prescaler #(
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      tick_o
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == prescale_i);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: programmable high/low phase lengths in prescaled ticks, with a
// one-deep pending config slot that is applied only on period boundaries.
`timescale 1ns/1ps
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      pwd_clk,
  input  logic                      sysreset,
  input  logic                      enable,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CNT_WIDTH-1:0]      cfg_high_count,
  input  logic [CNT_WIDTH-1:0]      cfg_low_count,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  output logic                      pwm_out,
  output logic                      period_start,
  output logic [CNT_WIDTH-1:0]      period_count,
  output logic                      busy
);

  typedef struct packed {
    logic [CNT_WIDTH-1:0]      high;
    logic [CNT_WIDTH-1:0]      low;
    logic [PRESCALE_WIDTH-1:0] prescale;
  } cfg_t;

  cfg_t                 act_q, act_d, pend_q, pend_d, next_cfg;
  logic                 loaded_q, loaded_d, pend_full_q, pend_full_d;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] phase_q, phase_d, pcount_q, pcount_d, phase_len;
  logic                 pwm_q, start_q;
  logic                 tick, phase_done, boundary, start_period, enter, xfer;

  assign cfg_ready    = !pend_full_q;
  assign pwm_out      = pwm_q;
  assign period_start = start_q;
  assign period_count = pcount_q;
  assign busy         = (state_q != ST_IDLE);

  // A new period picks up the pending config if one is waiting.
  assign next_cfg   = pend_full_q ? pend_q : act_q;
  assign phase_len  = (state_q == ST_HIGH) ? act_q.high : act_q.low;
  assign phase_done = tick && (phase_q == phase_len - CNT_WIDTH'(1));

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    loaded_d     = loaded_q;
    pcount_d     = pcount_q;
    phase_d      = phase_q;
    boundary     = 1'b0;
    start_period = 1'b0;
    enter        = 1'b0;
    xfer         = 1'b0;

    case (state_q)
      // Starting is held off while a transfer is due so a period never sees two configs.
      ST_IDLE: begin
        if (pend_full_q) xfer = 1'b1;
        else if (enable && loaded_q && (act_q.high != '0 || act_q.low != '0))
          start_period = 1'b1;
      end
      ST_HIGH: begin
        if (!enable) state_d = ST_IDLE;
        else if (phase_done) begin
          if (act_q.low != '0) begin
            state_d = ST_LOW;
            enter   = 1'b1;
          end else begin
            boundary = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (!enable)         state_d  = ST_IDLE;
        else if (phase_done) boundary = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (boundary) begin
      pcount_d = pcount_q + CNT_WIDTH'(1);
      xfer     = pend_full_q;
      if (next_cfg.high == '0 && next_cfg.low == '0) state_d = ST_IDLE;
      else start_period = 1'b1;
    end

    if (start_period) begin
      enter   = 1'b1;
      state_d = (next_cfg.high != '0) ? ST_HIGH : ST_LOW;
    end

    if (xfer) begin
      act_d       = pend_q;
      loaded_d    = 1'b1;
      pend_full_d = 1'b0;
    end

    // Acceptance needs an empty slot, so it can never coincide with a transfer.
    if (cfg_valid && !pend_full_q) begin
      pend_d      = '{high: cfg_high_count, low: cfg_low_count, prescale: cfg_prescale};
      pend_full_d = 1'b1;
    end

    if (enter || state_d == ST_IDLE) phase_d = '0;
    else if (tick)                   phase_d = phase_q + CNT_WIDTH'(1);
  end

  pwm_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk       (pwd_clk),
    .rst_n     (sysreset),
    .clear_i   (enter || state_d == ST_IDLE),
    .prescale_i(act_q.prescale),
    .tick_o    (tick)
  );

  always_ff @(posedge pwd_clk or negedge sysreset) begin
    if (!sysreset) begin
      state_q     <= ST_IDLE;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      loaded_q    <= 1'b0;
      phase_q     <= '0;
      pcount_q    <= '0;
      pwm_q       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      loaded_q    <= loaded_d;
      phase_q     <= phase_d;
      pcount_q    <= pcount_d;
      pwm_q       <= (state_d == ST_HIGH);
      start_q     <= start_period;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: hand-computed waveforms for timing, prescale,
// boundary-aligned config updates, degenerate configs, abort and async reset.
`timescale 1ns/1ps
module tb_pwm_gen;

  localparam int CW = 32;
  localparam int PW = 8;

  logic          pwd_clk        = 1'b0;
  logic          sysreset       = 1'b0;
  logic          enable         = 1'b0;
  logic          cfg_valid      = 1'b0;
  logic [CW-1:0] cfg_high_count = '0;
  logic [CW-1:0] cfg_low_count  = '0;
  logic [PW-1:0] cfg_prescale   = '0;
  logic          cfg_ready, pwm_out, period_start, busy;
  logic [CW-1:0] period_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 pwd_clk = ~pwd_clk;

  pwm_gen #(.CNT_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
    .pwd_clk       (pwd_clk),
    .sysreset      (sysreset),
    .enable        (enable),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_high_count(cfg_high_count),
    .cfg_low_count (cfg_low_count),
    .cfg_prescale  (cfg_prescale),
    .pwm_out       (pwm_out),
    .period_start  (period_start),
    .period_count  (period_count),
    .busy          (busy)
  );

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge pwd_clk);
    #1;
  endtask

  task automatic offer(input logic [CW-1:0] h, input logic [CW-1:0] l, input logic [PW-1:0] p);
    cfg_valid      = 1'b1;
    cfg_high_count = h;
    cfg_low_count  = l;
    cfg_prescale   = p;
  endtask

  initial begin
    // reset state
    #2;
    check_b("rst_ready", cfg_ready, 1'b1);
    check_b("rst_pwm", pwm_out, 1'b0);
    check_b("rst_ps", period_start, 1'b0);
    check_w("rst_count", period_count, 0);
    check_b("rst_busy", busy, 1'b0);
    #10 sysreset = 1'b1;
    step();
    check_b("idle_busy", busy, 1'b0);

    // basic 3/5, P=0
    enable = 1'b1;
    offer(3, 5, 0);
    step();
    check_b("acc_ready", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    step();
    check_b("xfer_ready", cfg_ready, 1'b1);
    check_b("xfer_pwm", pwm_out, 1'b0);
    step();
    check_b("first_pwm", pwm_out, 1'b1);
    check_b("first_ps", period_start, 1'b1);
    check_b("first_busy", busy, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      step();
      check_b("basic_pwm", pwm_out, (i % 8) < 3);
      check_b("basic_ps", period_start, (i % 8) == 0);
    end
    check_w("basic_count", period_count, 4);

    // mid-period update to 1/1, second offer 2/2 held while pending is full
    offer(1, 1, 0);
    step();
    check_b("upd_ready_lo", cfg_ready, 1'b0);
    offer(2, 2, 0);
    for (int j = 2; j <= 7; j++) begin
      step();
      check_b("upd_hold_ready", cfg_ready, 1'b0);
      check_b("upd_old_pwm", pwm_out, j < 3);
    end
    step();
    check_b("upd_b_pwm", pwm_out, 1'b1);
    check_b("upd_b_ps", period_start, 1'b1);
    check_b("upd_b_ready", cfg_ready, 1'b1);
    check_w("upd_b_count", period_count, 5);
    step();
    check_b("upd_11_low", pwm_out, 1'b0);
    check_b("upd_2nd_acc", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    step();
    check_b("upd_22_h0", pwm_out, 1'b1);
    check_b("upd_22_ps", period_start, 1'b1);
    check_w("upd_22_count", period_count, 6);
    step();
    check_b("upd_22_h1", pwm_out, 1'b1);
    check_b("upd_22_ps1", period_start, 1'b0);
    step();
    check_b("upd_22_l0", pwm_out, 1'b0);
    step();
    check_b("upd_22_l1", pwm_out, 1'b0);
    step();
    check_b("upd_22_next", period_start, 1'b1);
    check_w("upd_22_count2", period_count, 7);

    // degenerate H=0, L=4
    offer(0, 4, 0);
    step();
    cfg_valid = 1'b0;
    step(3);
    check_b("h0_ps", period_start, 1'b1);
    check_b("h0_pwm", pwm_out, 1'b0);
    check_w("h0_count", period_count, 8);
    for (int k = 1; k <= 8; k++) begin
      step();
      check_b("h0_pwm_run", pwm_out, 1'b0);
      check_b("h0_ps_run", period_start, (k % 4) == 0);
    end
    check_w("h0_count2", period_count, 10);

    // degenerate H=4, L=0
    offer(4, 0, 0);
    step();
    cfg_valid = 1'b0;
    step(3);
    check_b("l0_pwm", pwm_out, 1'b1);
    check_b("l0_ps", period_start, 1'b1);
    check_w("l0_count", period_count, 11);
    for (int m = 1; m <= 8; m++) begin
      step();
      check_b("l0_pwm_run", pwm_out, 1'b1);
      check_b("l0_ps_run", period_start, (m % 4) == 0);
    end
    check_w("l0_count2", period_count, 13);

    // load H=L=0 while running: idle after the current period, still counted
    offer(0, 0, 0);
    step();
    cfg_valid = 1'b0;
    step(3);
    check_b("zero_busy", busy, 1'b0);
    check_b("zero_pwm", pwm_out, 1'b0);
    check_b("zero_ps", period_start, 1'b0);
    check_b("zero_ready", cfg_ready, 1'b1);
    check_w("zero_count", period_count, 14);

    // abort mid-HIGH and restart
    offer(3, 5, 0);
    step();
    cfg_valid = 1'b0;
    step(2);
    check_b("ab_start_ps", period_start, 1'b1);
    check_w("ab_start_count", period_count, 14);
    step();
    check_b("ab_high", pwm_out, 1'b1);
    enable = 1'b0;
    step();
    check_b("ab_pwm", pwm_out, 1'b0);
    check_b("ab_busy", busy, 1'b0);
    check_w("ab_count", period_count, 14);
    enable = 1'b1;
    step();
    check_b("re_pwm0", pwm_out, 1'b1);
    check_b("re_ps", period_start, 1'b1);
    step();
    check_b("re_pwm1", pwm_out, 1'b1);
    step();
    check_b("re_pwm2", pwm_out, 1'b1);
    step();
    check_b("re_pwm3", pwm_out, 1'b0);
    check_b("re_ps3", period_start, 1'b0);

    // async reset mid-LOW with pending full
    offer(1, 1, 0);
    step();
    check_b("ar_pend", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    #3 sysreset = 1'b0;
    #1;
    check_b("ar_ready", cfg_ready, 1'b1);
    check_b("ar_pwm", pwm_out, 1'b0);
    check_b("ar_ps", period_start, 1'b0);
    check_w("ar_count", period_count, 0);
    check_b("ar_busy", busy, 1'b0);
    #2 sysreset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      check_b("ar_idle_busy", busy, 1'b0);
      check_b("ar_idle_pwm", pwm_out, 1'b0);
    end

    // prescale: 3/5 with P=1 -> 6 high / 10 low
    offer(3, 5, 1);
    step();
    cfg_valid = 1'b0;
    check_b("ps_acc_pwm", pwm_out, 1'b0);
    step();
    check_b("ps_xfer_pwm", pwm_out, 1'b0);
    step();
    check_b("ps_first_pwm", pwm_out, 1'b1);
    check_b("ps_first_ps", period_start, 1'b1);
    for (int i = 1; i <= 31; i++) begin
      step();
      check_b("ps_pwm", pwm_out, (i % 16) < 6);
      check_b("ps_ps", period_start, (i % 16) == 0);
    end
    check_w("ps_count", period_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
